mem_port_arbiter: RTL and testbench

- Shares one memory/bus port between the instruction-fetch requester (IF, read-only) and the data-memory requester (DM, read/write) of the RISC-V core.
- At most one transaction is outstanding. DM has fixed priority over IF, with an anti-starvation limit.
- Responses are routed back to the owning requester through registered response outputs.
- Sits between the core's fetch/memory stages and the shared memory or bus.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int unsigned MAX_STREAK_DEFAULT = 4;

  // Bits needed to count 0..max_streak inclusive.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: lock owner first, else DM unless IF has waited out a full streak.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = MAX_STREAK_DEFAULT,
  parameter int unsigned STREAK_W   = streak_width(MAX_STREAK)
) (
  input  logic                if_valid,
  input  logic                dm_valid,
  input  logic                lock,
  input  owner_e              lock_owner,
  input  logic [STREAK_W-1:0] streak,
  output logic                win_valid,
  output owner_e              win_owner
);

  // Locked owner keeps its valid held, so a lock always implies a winner.
  always_comb begin
    win_valid = 1'b0;
    win_owner = OWN_IF;
    if (lock) begin
      win_valid = 1'b1;
      win_owner = lock_owner;
    end else if (dm_valid && !(if_valid && (streak == STREAK_W'(MAX_STREAK)))) begin
      win_valid = 1'b1;
      win_owner = OWN_DM;
    end else if (if_valid) begin
      win_valid = 1'b1;
      win_owner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory, one transaction in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = MAX_STREAK_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                dm_req_valid,
  input  logic [ADDR_W-1:0]   dm_req_addr,
  input  logic [DATA_W-1:0]   dm_req_wdata,
  input  logic [DATA_W/8-1:0] dm_req_wmask,
  output logic                dm_req_ready,
  output logic                dm_resp_valid,
  output logic [DATA_W-1:0]   dm_resp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int unsigned STREAK_W = streak_width(MAX_STREAK);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                lock_q, lock_d;
  owner_e              lock_owner_q, lock_owner_d;
  logic                if_resp_valid_d, dm_resp_valid_d;
  logic [DATA_W-1:0]   if_resp_data_d, dm_resp_data_d;
  logic                win_valid;
  owner_e              win_owner;

  mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .STREAK_W   (STREAK_W)
  ) u_pick (
    .if_valid   (if_req_valid),
    .dm_valid   (dm_req_valid),
    .lock       (lock_q),
    .lock_owner (lock_owner_q),
    .streak     (streak_q),
    .win_valid  (win_valid),
    .win_owner  (win_owner)
  );

  // State, streak counter, lock and registered responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      streak_q      <= '0;
      lock_q        <= 1'b0;
      lock_owner_q  <= OWN_IF;
      if_resp_valid <= 1'b0;
      dm_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      dm_resp_data  <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      lock_q        <= lock_d;
      lock_owner_q  <= lock_owner_d;
      if_resp_valid <= if_resp_valid_d;
      dm_resp_valid <= dm_resp_valid_d;
      if_resp_data  <= if_resp_data_d;
      dm_resp_data  <= dm_resp_data_d;
    end
  end

  // Next-state, request mux/ready pass-through and response capture.
  always_comb begin
    state_d         = state_q;
    streak_d        = streak_q;
    lock_d          = lock_q;
    lock_owner_d    = lock_owner_q;
    if_resp_valid_d = 1'b0;
    dm_resp_valid_d = 1'b0;
    if_resp_data_d  = if_resp_data;
    dm_resp_data_d  = dm_resp_data;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    mem_req_wmask   = '0;
    if_req_ready    = 1'b0;
    dm_req_ready    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          mem_req_valid = 1'b1;
          if (win_owner == OWN_DM) begin
            mem_req_addr  = dm_req_addr;
            mem_req_wdata = dm_req_wdata;
            mem_req_wmask = dm_req_wmask;
          end else begin
            mem_req_addr  = if_req_addr;
          end

          if (mem_req_ready) begin
            lock_d = 1'b0;
            if (win_owner == OWN_DM) begin
              dm_req_ready = 1'b1;
              state_d      = ST_WAIT_D;
              // Count DM grants only while IF is actually being held off.
              if (!if_req_valid) begin
                streak_d = '0;
              end else if (streak_q != STREAK_W'(MAX_STREAK)) begin
                streak_d = streak_q + STREAK_W'(1);
              end
            end else begin
              if_req_ready = 1'b1;
              state_d      = ST_WAIT_I;
              streak_d     = '0;
            end
          end else begin
            // Keep presenting the same owner until the memory takes it.
            lock_d       = 1'b1;
            lock_owner_d = win_owner;
          end
        end
      end

      ST_WAIT_I: begin
        if (mem_resp_valid) begin
          if_resp_valid_d = 1'b1;
          if_resp_data_d  = mem_resp_data;
          state_d         = ST_IDLE;
        end
      end

      ST_WAIT_D: begin
        if (mem_resp_valid) begin
          dm_resp_valid_d = 1'b1;
          dm_resp_data_d  = mem_resp_data;
          state_d         = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-table bench for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_IF   = 2'd1;
  localparam logic [1:0] R_DM   = 2'd2;
  localparam logic [1:0] R_DMW  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        dm_req_valid;
  logic [31:0] dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic [3:0]  dm_req_wmask;
  logic        dm_req_ready;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_STREAK (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_resp_valid  (if_resp_valid),
    .if_resp_data   (if_resp_data),
    .dm_req_valid   (dm_req_valid),
    .dm_req_addr    (dm_req_addr),
    .dm_req_wdata   (dm_req_wdata),
    .dm_req_wmask   (dm_req_wmask),
    .dm_req_ready   (dm_req_ready),
    .dm_resp_valid  (dm_resp_valid),
    .dm_resp_data   (dm_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        if_v;
    logic [31:0] if_a;
    logic        dm_v;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [3:0]  dm_wm;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  route;
    logic        e_ir;
    logic        e_dr;
    logic        e_mv;
    logic [31:0] e_ma;
    logic [31:0] e_mwd;
    logic [3:0]  e_mwm;
  } vec_t;

  typedef struct {
    logic [1:0]  route;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t row(
    input logic rst_i, input logic if_v, input logic [31:0] if_a,
    input logic dm_v, input logic [31:0] dm_a, input logic [31:0] dm_wd, input logic [3:0] dm_wm,
    input logic rdy, input logic rv, input logic [31:0] rd, input logic [1:0] route,
    input logic e_ir, input logic e_dr, input logic e_mv,
    input logic [31:0] e_ma, input logic [31:0] e_mwd, input logic [3:0] e_mwm);
    vec_t v;
    v.rst_n = rst_i; v.if_v = if_v; v.if_a = if_a;
    v.dm_v = dm_v; v.dm_a = dm_a; v.dm_wd = dm_wd; v.dm_wm = dm_wm;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.route = route;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_mv = e_mv;
    v.e_ma = e_ma; v.e_mwd = e_mwd; v.e_mwm = e_mwm;
    return v;
  endfunction

  function automatic vec_t idle_row(input logic rv, input logic [31:0] rd, input logic [1:0] route);
    return row(1, 0, 0, 0, 0, 0, 0, 1, rv, rd, route, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n          = v.rst_n;
    if_req_valid   = v.if_v;
    if_req_addr    = v.if_a;
    dm_req_valid   = v.dm_v;
    dm_req_addr    = v.dm_a;
    dm_req_wdata   = v.dm_wd;
    dm_req_wmask   = v.dm_wm;
    mem_req_ready  = v.rdy;
    mem_resp_valid = v.rv;
    mem_resp_data  = v.rd;
  endtask

  // Response outputs now visible come from the previous cycle's memory response.
  task automatic check_resp(input string name);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, " resp_valid"}, 128'({if_resp_valid, dm_resp_valid}),
            128'({e.route == R_IF, (e.route == R_DM) || (e.route == R_DMW)}));
      if (e.route == R_IF)
        check({name, " if_resp_data"}, 128'(if_resp_data), 128'(e.data));
      else if (e.route == R_DM)
        check({name, " dm_resp_data"}, 128'(dm_resp_data), 128'(e.data));
    end else begin
      check({name, " no_resp"}, 128'({if_resp_valid, dm_resp_valid}), 128'(2'b00));
    end
  endtask

  initial begin
    vec_t v;
    logic [70:0] act_b, exp_b;
    bit is_if;

    // Single IF read, memory latency 2.
    vecs.push_back(row(1, 1, 32'h1000, 0, 0, 0, 0, 1, 0, 0, R_NONE, 1, 0, 1, 32'h1000, 0, 0));
    vecs.push_back(idle_row(0, 0, R_NONE));
    vecs.push_back(idle_row(1, 32'hDEADBEEF, R_IF));
    vecs.push_back(idle_row(0, 0, R_NONE));
    vecs.push_back(idle_row(0, 0, R_NONE));
    // Simultaneous IF and DM write: DM first, IF right after the DM ack.
    vecs.push_back(row(1, 1, 32'h1004, 1, 32'h2000, 32'h55, 4'hF, 1, 0, 0, R_NONE, 0, 1, 1, 32'h2000, 32'h55, 4'hF));
    vecs.push_back(row(1, 1, 32'h1004, 0, 0, 0, 0, 1, 0, 0, R_NONE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 1, 32'h1004, 0, 0, 0, 0, 1, 1, 32'h12345678, R_DMW, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 1, 32'h1004, 0, 0, 0, 0, 1, 0, 0, R_NONE, 1, 0, 1, 32'h1004, 0, 0));
    vecs.push_back(idle_row(1, 32'hCAFEF00D, R_IF));
    vecs.push_back(idle_row(0, 0, R_NONE));
    // Both continuously valid: four DM grants, then IF, repeated.
    for (int k = 0; k < 10; k++) begin
      is_if = (k == 4) || (k == 9);
      vecs.push_back(row(1, 1, 32'h3000, 1, 32'h4000, 0, 0, 1, 0, 0, R_NONE,
                         is_if, !is_if, 1, is_if ? 32'h3000 : 32'h4000, 0, 0));
      vecs.push_back(row(1, 1, 32'h3000, 1, 32'h4000, 0, 0, 1, 1, 32'h5000 + 32'(k),
                         is_if ? R_IF : R_DM, 0, 0, 0, 0, 0, 0));
    end
    vecs.push_back(idle_row(0, 0, R_NONE));
    // IF stalled by memory; lock keeps IF presented after DM arrives.
    vecs.push_back(row(1, 1, 32'h6000, 0, 0, 0, 0, 0, 0, 0, R_NONE, 0, 0, 1, 32'h6000, 0, 0));
    vecs.push_back(row(1, 1, 32'h6000, 0, 0, 0, 0, 0, 0, 0, R_NONE, 0, 0, 1, 32'h6000, 0, 0));
    vecs.push_back(row(1, 1, 32'h6000, 0, 0, 0, 0, 0, 0, 0, R_NONE, 0, 0, 1, 32'h6000, 0, 0));
    vecs.push_back(row(1, 1, 32'h6000, 1, 32'h7000, 32'hAA, 4'h3, 0, 0, 0, R_NONE, 0, 0, 1, 32'h6000, 0, 0));
    vecs.push_back(row(1, 1, 32'h6000, 1, 32'h7000, 32'hAA, 4'h3, 1, 0, 0, R_NONE, 1, 0, 1, 32'h6000, 0, 0));
    vecs.push_back(row(1, 0, 0, 1, 32'h7000, 32'hAA, 4'h3, 1, 1, 32'h600D, R_IF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 0, 0, 1, 32'h7000, 32'hAA, 4'h3, 1, 0, 0, R_NONE, 0, 1, 1, 32'h7000, 32'hAA, 4'h3));
    vecs.push_back(idle_row(1, 32'h7777, R_DMW));
    vecs.push_back(idle_row(0, 0, R_NONE));
    // Reset while waiting on DM; the late memory response must be dropped.
    vecs.push_back(row(1, 0, 0, 1, 32'h8000, 0, 0, 1, 0, 0, R_NONE, 0, 1, 1, 32'h8000, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, R_NONE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle_row(0, 0, R_NONE));
    vecs.push_back(idle_row(1, 32'h00000BAD, R_NONE));
    vecs.push_back(idle_row(0, 0, R_NONE));
    vecs.push_back(row(1, 1, 32'h9000, 0, 0, 0, 0, 1, 0, 0, R_NONE, 1, 0, 1, 32'h9000, 0, 0));
    vecs.push_back(idle_row(1, 32'h9999, R_IF));
    vecs.push_back(idle_row(0, 0, R_NONE));
    // Spurious memory response while idle.
    vecs.push_back(idle_row(1, 32'h1111, R_NONE));
    vecs.push_back(idle_row(0, 0, R_NONE));
    vecs.push_back(row(1, 1, 32'hA000, 0, 0, 0, 0, 1, 0, 0, R_NONE, 1, 0, 1, 32'hA000, 0, 0));
    vecs.push_back(idle_row(1, 32'hA5A5A5A5, R_IF));
    vecs.push_back(idle_row(0, 0, R_NONE));

    // Reset state.
    v = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R_NONE, 0, 0, 0, 0, 0, 0);
    apply(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset resp", 128'({if_resp_valid, dm_resp_valid, if_resp_data, dm_resp_data}), 128'(0));
    check("reset req", 128'({mem_req_valid, if_req_ready, dm_req_ready}), 128'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      v = vecs[i];
      apply(v);
      #1;
      act_b = {if_req_ready, dm_req_ready, mem_req_valid,
               v.e_mv ? mem_req_addr : 32'h0, v.e_mv ? mem_req_wdata : 32'h0,
               v.e_mv ? mem_req_wmask : 4'h0};
      exp_b = {v.e_ir, v.e_dr, v.e_mv, v.e_ma, v.e_mwd, v.e_mwm};
      check($sformatf("row%0d req", i), 128'(act_b), 128'(exp_b));
      check_resp($sformatf("row%0d", i));
      if (v.route != R_NONE) begin
        exp_t e;
        e.route = v.route;
        e.data  = v.rd;
        sb.push_back(e);
      end
    end

    @(negedge clk);
    apply(idle_row(0, 0, R_NONE));
    #1;
    check_resp("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
